uart_tx: RTL and testbench

Serial transmitter stage. It sits directly downstream of the APB register block and consumes its tx_data, frame-configuration and start_tx outputs. It produces a UART line (start bit, 5-8 data bits LSB first, optional parity, 1-2 stop bits) and returns tx_done to the status register.

---
 rtl/uart_pkg.sv | 50 +++++
 rtl/uart_tx_if.sv | 23 ++
 rtl/uart_baud_cnt.sv | 32 +++
 rtl/uart_tx.sv | 168 ++++++++++++++++
 tb/tb_uart_tx.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, data-length codes and parity helpers.
// Used by uart_tx and the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  function automatic logic [3:0] data_bit_count(input logic [1:0] dbn);
    logic [3:0] cnt;
    case (dbn)
      DBITS_5: cnt = 4'd5;
      DBITS_6: cnt = 4'd6;
      DBITS_7: cnt = 4'd7;
      DBITS_8: cnt = 4'd8;
      default: cnt = 4'd8;
    endcase
    return cnt;
  endfunction

  // Odd parity starts from 1 so the result is the inverse of the even XOR.
  function automatic logic calc_parity(input logic [7:0] data, input logic [1:0] dbn,
                                       input logic ptype);
    logic p;
    logic [3:0] n;
    p = (ptype == PARITY_ODD) ? 1'b1 : 1'b0;
    n = data_bit_count(dbn);
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < n) begin
        p = p ^ data[i];
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Frame request / status bundle between the APB register block (master)
// and the serial transmitter (slave).
interface uart_tx_if;
  logic [7:0] tx_data;
  logic [1:0] data_bit_num;
  logic       stop_bit_num;
  logic       parity_en;
  logic       parity_type;
  logic       start_tx;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_data, data_bit_num, stop_bit_num, parity_en, parity_type, start_tx,
    input  tx, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, data_bit_num, stop_bit_num, parity_en, parity_type, start_tx,
    output tx, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while clear is low and flags
// the terminal count. Shared with the receiver.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tc
);

  logic [CNT_W-1:0] cnt_r;
  logic             at_end_s;

  assign at_end_s = (cnt_r == CNT_W'(CLKS_PER_BIT - 1));
  assign tc       = at_end_s & ~clear;

  // Period counter, wraps to zero on terminal count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (at_end_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, 5-8 data bits LSB first, optional parity,
// 1-2 stop bits. Optional line break via `define UART_TX_BREAK_EN.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
`ifdef UART_TX_BREAK_EN
  input  logic       tx_break,
`endif
  uart_tx_if.slave   bus
);

  tx_state_t  state_r, state_s;
  logic       start_q_r;
  logic [7:0] sh_data_r;
  logic [1:0] sh_dbn_r;
  logic       sh_sbn_r, sh_pen_r, sh_pty_r;
  logic [2:0] idx_r, idx_s, last_idx_s;
  logic [3:0] nbits_s;
  logic       tx_r, tx_s, busy_r, busy_s, done_r, done_s;
  logic       load_s, req_s, tc_s, brk_s;

`ifdef UART_TX_BREAK_EN
  assign brk_s = tx_break;
`else
  assign brk_s = 1'b0;
`endif

  assign req_s      = bus.start_tx & ~start_q_r;
  assign nbits_s    = data_bit_count(sh_dbn_r);
  assign last_idx_s = nbits_s[2:0] - 3'd1;

  assign bus.tx      = tx_r;
  assign bus.tx_busy = busy_r;
  assign bus.tx_done = done_r;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(state_r == IDLE),
    .tc   (tc_s)
  );

  // Next-state, bit index, status flags and next line value
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    busy_s  = busy_r;
    done_s  = done_r;
    load_s  = 1'b0;
    tx_s    = 1'b1;
    if (brk_s) begin
      state_s = IDLE;
      idx_s   = 3'd0;
      busy_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            load_s  = 1'b1;
            state_s = START;
            idx_s   = 3'd0;
            busy_s  = 1'b1;
            done_s  = 1'b0;
          end else begin
            state_s = IDLE;
          end
        end
        START: begin
          if (tc_s) state_s = DATA;
          else      state_s = START;
        end
        DATA: begin
          if (tc_s && (idx_r == last_idx_s)) begin
            idx_s   = 3'd0;
            state_s = sh_pen_r ? PARITY : STOP;
          end else if (tc_s) begin
            idx_s = idx_r + 3'd1;
          end else begin
            idx_s = idx_r;
          end
        end
        PARITY: begin
          if (tc_s) state_s = STOP;
          else      state_s = PARITY;
        end
        STOP: begin
          // idx selects first/second stop bit; last one ends the frame
          if (tc_s && (idx_r[0] == sh_sbn_r)) begin
            state_s = IDLE;
            idx_s   = 3'd0;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else if (tc_s) begin
            idx_s = 3'd1;
          end else begin
            idx_s = idx_r;
          end
        end
        default: begin
          state_s = IDLE;
          idx_s   = 3'd0;
          busy_s  = 1'b0;
        end
      endcase
    end
    case (state_s)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = sh_data_r[idx_s];
      PARITY:  tx_s = calc_parity(sh_data_r, sh_dbn_r, sh_pty_r);
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
    if (brk_s) tx_s = 1'b0;
    else       tx_s = tx_s;
  end

  // State, status and registered line output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      idx_r     <= 3'd0;
      start_q_r <= 1'b0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      start_q_r <= bus.start_tx;
      tx_r      <= tx_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  // Frame configuration captured at acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_data_r <= 8'h00;
      sh_dbn_r  <= DBITS_8;
      sh_sbn_r  <= 1'b0;
      sh_pen_r  <= 1'b0;
      sh_pty_r  <= PARITY_EVEN;
    end else if (load_s) begin
      sh_data_r <= bus.tx_data;
      sh_dbn_r  <= bus.data_bit_num;
      sh_sbn_r  <= bus.stop_bit_num;
      sh_pen_r  <= bus.parity_en;
      sh_pty_r  <= bus.parity_type;
    end else begin
      sh_data_r <= sh_data_r;
      sh_dbn_r  <= sh_dbn_r;
      sh_sbn_r  <= sh_sbn_r;
      sh_pen_r  <= sh_pen_r;
      sh_pty_r  <= sh_pty_r;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected line waveform built as a bit list
// from the frame rules, compared cycle by cycle.
module tb_uart_tx;

  localparam int CPB = 4;

  logic clk;
  logic reset;
  int   nvec;
  int   nerr;

  uart_tx_if bus ();

`ifdef UART_TX_BREAK_EN
  logic brk;
  initial brk = 1'b0;
  uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .tx_break(brk), .bus(bus)
  );
`else
  uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // mode: 0 plain, 1 hold start high, 2 toggle start mid-frame, 3 change inputs mid-frame
  task automatic run_frame(input logic [7:0] d, input logic [1:0] dbn, input logic sbn,
                           input logic pen, input logic pty, input int mode,
                           input bit pre, input bit b2b);
    logic q[$];
    int   n, ones, len;
    n    = 5 + int'(dbn);
    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pen) q.push_back(((ones % 2) == 1) ^ pty);
    q.push_back(1'b1);
    if (sbn) q.push_back(1'b1);
    len = q.size() * CPB;

    bus.tx_data      = d;
    bus.data_bit_num = dbn;
    bus.stop_bit_num = sbn;
    bus.parity_en    = pen;
    bus.parity_type  = pty;
    if (!pre) begin
      @(negedge clk);
      bus.start_tx = 1'b1;
    end
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      chk("tx", bus.tx, q[k / CPB]);
      chk("busy", bus.tx_busy, 1'b1);
      if (k == 0) chk("done_clr", bus.tx_done, 1'b0);
      if (mode == 2 && k == 3 * CPB) bus.start_tx = 1'b0;
      if (mode == 2 && k == 3 * CPB + 2) bus.start_tx = 1'b1;
      if (mode == 3 && k == 2 * CPB) begin
        bus.tx_data      = 8'($urandom);
        bus.data_bit_num = 2'($urandom_range(0, 3));
        bus.stop_bit_num = ~sbn;
        bus.parity_en    = ~pen;
        bus.parity_type  = ~pty;
      end
      if (b2b && k == len - 1) bus.start_tx = 1'b0;
    end
    @(negedge clk);
    chk("busy_end", bus.tx_busy, 1'b0);
    chk("done_set", bus.tx_done, 1'b1);
    chk("tx_idle", bus.tx, 1'b1);
    if (mode == 1 || mode == 2) begin
      repeat (100) begin
        @(negedge clk);
        chk("no_refire_busy", bus.tx_busy, 1'b0);
        chk("no_refire_tx", bus.tx, 1'b1);
      end
    end
    if (b2b) bus.start_tx = 1'b1;
    else     bus.start_tx = 1'b0;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    reset = 1'b1;
    bus.start_tx     = 1'b0;
    bus.tx_data      = 8'h00;
    bus.data_bit_num = 2'b11;
    bus.stop_bit_num = 1'b0;
    bus.parity_en    = 1'b0;
    bus.parity_type  = 1'b0;
    #3;
    chk("rst_tx", bus.tx, 1'b1);
    chk("rst_busy", bus.tx_busy, 1'b0);
    chk("rst_done", bus.tx_done, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    run_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);  // 8N1
    run_frame(8'hFF, 2'b00, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);  // 5E2
    run_frame(8'hFF, 2'b00, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0);  // 5O2
    run_frame(8'h80, 2'b10, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0);  // 7O1
    run_frame(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    run_frame(8'h33, 2'b01, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    run_frame(8'hC3, 2'b11, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    run_frame(8'h0F, 2'b01, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    run_frame(8'h96, 2'b11, 1'b1, 1'b1, 1'b1, 3, 1'b0, 1'b0);

    // reset in the middle of the data bits
    bus.tx_data      = 8'h3C;
    bus.data_bit_num = 2'b11;
    bus.stop_bit_num = 1'b0;
    bus.parity_en    = 1'b0;
    @(negedge clk);
    bus.start_tx = 1'b1;
    repeat (4 * CPB + 2) @(negedge clk);
    chk("pre_rst_busy", bus.tx_busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("arst_tx", bus.tx, 1'b1);
    chk("arst_busy", bus.tx_busy, 1'b0);
    chk("arst_done", bus.tx_done, 1'b0);
    bus.start_tx = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_frame(8'h69, 2'b11, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      run_frame(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
